crg_reset_sequencer: RTL and testbench

- Consumer side of the top-level PLL: drives the PLL's ARESET input and watches its LOCKED output.
- Releases the system reset only after lock has been held stable for a programmable time.
- Re-resets the PLL if lock is never achieved (timeout) or is lost during run.
- Clocked from the free-running board input clock (the PLL reference), never from a PLL output, so it keeps running while the PLL is held in reset.

---
 rtl/crg_pkg.sv | 36 +++
 rtl/crg_reset_sequencer_if.sv | 47 ++++
 rtl/crg_sync.sv | 34 +++
 rtl/crg_reset_sequencer.sv | 136 +++++++++++++
 tb/tb_crg_reset_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crg_pkg
//  Description : Shared types and defaults for the PLL reset sequencer.
//                - crg_state_e : sequencer state encoding (2 bits)
//                - default ARESET / LOCK_TIMEOUT / STABLE cycle counts
//                - width of the saturating status counters
//                - max3() helper used to size the internal counter
//  Revision    : 1.0  initial release
// ============================================================================
package crg_pkg;

    typedef enum logic [1:0] {
        S_PLL_RESET = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } crg_state_e;

    localparam int c_ARESET_CYCLES_DEF = 16;
    localparam int c_LOCK_TIMEOUT_DEF  = 50000;
    localparam int c_STABLE_CYCLES_DEF = 1024;

    // Width of RETRY_CNT / LOSS_CNT
    localparam int c_STAT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage : crg_pkg
`default_nettype wire

// File: rtl/crg_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : crg_reset_sequencer_if
//  Description : PLL-side and system-side signals of the reset sequencer.
//                PLL_LOCKED   : PLL lock status (asynchronous to CLK)
//                SW_RESET_REQ : single-cycle request to re-run system reset
//                PLL_ARESET   : PLL reset, active high
//                RESET_OUT_N  : downstream system reset, active low
//                READY        : sequencer is in the run state
//                RETRY_CNT    : saturating count of lock timeouts
//                LOSS_CNT     : saturating count of lock losses while running
//                master modport: the sequencer; slave modport: PLL + system.
//  Revision    : 1.0  initial release
// ============================================================================
interface crg_reset_sequencer_if;
    import crg_pkg::*;

    logic                PLL_LOCKED;
    logic                SW_RESET_REQ;
    logic                PLL_ARESET;
    logic                RESET_OUT_N;
    logic                READY;
    logic [c_STAT_W-1:0] RETRY_CNT;
    logic [c_STAT_W-1:0] LOSS_CNT;

    modport master (
        input  PLL_LOCKED,
        input  SW_RESET_REQ,
        output PLL_ARESET,
        output RESET_OUT_N,
        output READY,
        output RETRY_CNT,
        output LOSS_CNT
    );

    modport slave (
        output PLL_LOCKED,
        output SW_RESET_REQ,
        input  PLL_ARESET,
        input  RESET_OUT_N,
        input  READY,
        input  RETRY_CNT,
        input  LOSS_CNT
    );

endinterface : crg_reset_sequencer_if
`default_nettype wire

// File: rtl/crg_sync.sv
`default_nettype none
// ============================================================================
//  Module      : crg_sync
//  Description : Two-flop synchronizer, asynchronous active-low reset to 0.
//                clk   : destination clock
//                rst_n : asynchronous reset, active low
//                i_d   : asynchronous input
//                o_q   : synchronized output (2 cycles of latency)
//  Revision    : 1.0  initial release
// ============================================================================
module crg_sync (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : crg_sync
`default_nettype wire

// File: rtl/crg_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : crg_reset_sequencer
//  Description : Drives the PLL ARESET input and releases the system reset
//                once PLL lock has been stable for STABLE_CYCLES cycles.
//                Re-resets the PLL on lock timeout or on lock loss in run.
//                Runs from the free-running PLL reference clock.
//                CLK     : reference clock (same net as PLL INCLK)
//                RESET_N : asynchronous reset, active low
//                bus     : PLL / system signals (master modport)
//  Revision    : 1.0  initial release
// ============================================================================
module crg_reset_sequencer
    import crg_pkg::*;
#(
    parameter int ARESET_CYCLES = c_ARESET_CYCLES_DEF,
    parameter int LOCK_TIMEOUT  = c_LOCK_TIMEOUT_DEF,
    parameter int STABLE_CYCLES = c_STABLE_CYCLES_DEF,
    parameter int CNT_W         = $clog2(max3(ARESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1
) (
    input  wire logic             CLK,
    input  wire logic             RESET_N,
    crg_reset_sequencer_if.master bus
);

    localparam logic [CNT_W-1:0]    c_ARESET_LAST  = CNT_W'(ARESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    c_STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_CNT_ONE      = CNT_W'(1);
    localparam logic [c_STAT_W-1:0] c_STAT_MAX     = '1;
    localparam logic [c_STAT_W-1:0] c_STAT_ONE     = c_STAT_W'(1);

    logic                w_lock_s;
    crg_state_e          r_state;
    crg_state_e          w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_retry_inc;
    logic                w_loss_inc;
    logic                r_pll_areset;
    logic                r_reset_out_n;
    logic                r_ready;
    logic [c_STAT_W-1:0] r_retry_cnt;
    logic [c_STAT_W-1:0] r_loss_cnt;

    crg_sync u_lock_sync (
        .clk   (CLK),
        .rst_n (RESET_N),
        .i_d   (bus.PLL_LOCKED),
        .o_q   (w_lock_s)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + c_CNT_ONE;
        w_retry_inc  = 1'b0;
        w_loss_inc   = 1'b0;

        case (r_state)
            S_PLL_RESET: begin
                if (r_cnt == c_ARESET_LAST) begin
                    w_state_next = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Lock has priority over a timeout landing on the same cycle.
                if (w_lock_s) begin
                    w_state_next = S_STABLE;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_state_next = S_PLL_RESET;
                    w_retry_inc  = 1'b1;
                end
            end
            S_STABLE: begin
                if (!w_lock_s) begin
                    w_state_next = S_WAIT_LOCK;
                end else if (r_cnt == c_STABLE_LAST) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // No timing in run; hold the counter so it cannot wrap.
                w_cnt_next = r_cnt;
                // Lock loss has priority over a software request.
                if (!w_lock_s) begin
                    w_state_next = S_PLL_RESET;
                    w_loss_inc   = 1'b1;
                end else if (bus.SW_RESET_REQ) begin
                    w_state_next = S_STABLE;
                end
            end
            default: begin
                w_state_next = S_PLL_RESET;
            end
        endcase

        // Every state entry restarts the counter.
        if (w_state_next != r_state) begin
            w_cnt_next = '0;
        end
    end

    // Outputs are decoded from the next state so they switch on the same
    // edge as the state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state       <= S_PLL_RESET;
            r_cnt         <= '0;
            r_pll_areset  <= 1'b1;
            r_reset_out_n <= 1'b0;
            r_ready       <= 1'b0;
            r_retry_cnt   <= '0;
            r_loss_cnt    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_pll_areset  <= (w_state_next == S_PLL_RESET);
            r_reset_out_n <= (w_state_next == S_RUN);
            r_ready       <= (w_state_next == S_RUN);
            if (w_retry_inc && (r_retry_cnt != c_STAT_MAX)) begin
                r_retry_cnt <= r_retry_cnt + c_STAT_ONE;
            end
            if (w_loss_inc && (r_loss_cnt != c_STAT_MAX)) begin
                r_loss_cnt <= r_loss_cnt + c_STAT_ONE;
            end
        end
    end

    assign bus.PLL_ARESET  = r_pll_areset;
    assign bus.RESET_OUT_N = r_reset_out_n;
    assign bus.READY       = r_ready;
    assign bus.RETRY_CNT   = r_retry_cnt;
    assign bus.LOSS_CNT    = r_loss_cnt;

endmodule : crg_reset_sequencer
`default_nettype wire

// File: tb/tb_crg_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crg_reset_sequencer
//  Description : Self-checking bench for crg_reset_sequencer with
//                ARESET_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_crg_reset_sequencer;

    localparam int A = 4;
    localparam int T = 32;
    localparam int S = 8;
    localparam int P = A + T;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    crg_reset_sequencer_if bus_if ();

    crg_reset_sequencer #(
        .ARESET_CYCLES (A),
        .LOCK_TIMEOUT  (T),
        .STABLE_CYCLES (S)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int total     = 0;
    int bad       = 0;
    int exp_retry = 0;
    int exp_loss  = 0;

    // ------------------------------------------------------------------
    // Reference model: phase + cycles-remaining timers
    // ------------------------------------------------------------------
    typedef enum int {PH_ARST, PH_WAIT, PH_QUAL, PH_RUN} phase_e;
    phase_e m_phase;
    int     m_left;
    bit     m_s1, m_s2;
    int     m_retry, m_loss;

    task automatic model_reset();
        m_phase = PH_ARST; m_left = A; m_s1 = 0; m_s2 = 0; m_retry = 0; m_loss = 0;
    endtask

    task automatic model_step(input bit lk, input bit sw);
        bit seen;
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        case (m_phase)
            PH_ARST: begin
                m_left--;
                if (m_left == 0) begin m_phase = PH_WAIT; m_left = T; end
            end
            PH_WAIT: begin
                if (seen) begin
                    m_phase = PH_QUAL; m_left = S;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = PH_ARST; m_left = A;
                        if (m_retry < 255) m_retry++;
                    end
                end
            end
            PH_QUAL: begin
                if (!seen) begin
                    m_phase = PH_WAIT; m_left = T;
                end else begin
                    m_left--;
                    if (m_left == 0) m_phase = PH_RUN;
                end
            end
            default: begin
                if (!seen) begin
                    m_phase = PH_ARST; m_left = A;
                    if (m_loss < 255) m_loss++;
                end else if (sw) begin
                    m_phase = PH_QUAL; m_left = S;
                end
            end
        endcase
    endtask

    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus_if.SW_RESET_REQ = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_for_run(output int n, output bit saw_areset);
        n = 0;
        saw_areset = 0;
        do begin
            tick();
            n++;
            if (bus_if.PLL_ARESET === 1'b1) saw_areset = 1;
        end while (bus_if.RESET_OUT_N !== 1'b1 && n < 400);
    endtask

    // Drop lock in run, then wait until the PLL reset pulse is over.
    task automatic lose_lock_and_wait();
        int n;
        bus_if.PLL_LOCKED = 1'b0;
        n = 0;
        while (bus_if.PLL_ARESET !== 1'b1 && n < 20) begin tick(); n++; end
        while (bus_if.PLL_ARESET === 1'b1 && n < 40) begin tick(); n++; end
        exp_loss++;
        total++;
        if (n >= 40) begin
            bad++;
            $display("FAIL lose_lock_pulse got=timeout want=pulse_done");
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus_if.PLL_ARESET, bus_if.RESET_OUT_N, bus_if.READY} !== 3'b100) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=100",
                     {bus_if.PLL_ARESET, bus_if.RESET_OUT_N, bus_if.READY});
        end
        total++;
        if (bus_if.RETRY_CNT !== 8'd0 || bus_if.LOSS_CNT !== 8'd0) begin
            bad++;
            $display("FAIL reset_counts got=%0d/%0d want=0/0", bus_if.RETRY_CNT, bus_if.LOSS_CNT);
        end
    endtask

    task automatic test_bringup();
        int n;
        bit saw;
        bus_if.PLL_LOCKED = 1'b0;
        do_reset();
        n = 0;
        while (bus_if.PLL_ARESET === 1'b1 && n < 100) begin tick(); n++; end
        total++;
        if (n != A) begin
            bad++;
            $display("FAIL bringup_areset_width got=%0d want=%0d", n, A);
        end
        repeat (10) tick();
        bus_if.PLL_LOCKED = 1'b1;
        wait_for_run(n, saw);
        total++;
        if (n != S + 3 || saw) begin
            bad++;
            $display("FAIL bringup_release_latency got=%0d areset=%0b want=%0d areset=0", n, saw, S + 3);
        end
        total++;
        if (bus_if.READY !== 1'b1 || bus_if.RETRY_CNT !== 8'd0) begin
            bad++;
            $display("FAIL bringup_ready_retry got=%b/%0d want=1/0", bus_if.READY, bus_if.RETRY_CNT);
        end
    endtask

    task automatic test_sw_reset();
        int  low;
        bit  saw, ready_low;
        bus_if.SW_RESET_REQ = 1'b1;
        tick();
        bus_if.SW_RESET_REQ = 1'b0;
        ready_low = (bus_if.READY === 1'b0);
        low = 0;
        saw = 0;
        while (bus_if.RESET_OUT_N !== 1'b1 && low < 100) begin
            low++;
            if (bus_if.PLL_ARESET === 1'b1) saw = 1;
            tick();
        end
        total++;
        if (low != S || saw || !ready_low) begin
            bad++;
            $display("FAIL sw_reset_low_width got=%0d areset=%0b ready_low=%0b want=%0d areset=0 ready_low=1",
                     low, saw, ready_low, S);
        end
        total++;
        if (bus_if.RETRY_CNT !== 8'(exp_retry) || bus_if.LOSS_CNT !== 8'(exp_loss)) begin
            bad++;
            $display("FAIL sw_reset_counts got=%0d/%0d want=%0d/%0d",
                     bus_if.RETRY_CNT, bus_if.LOSS_CNT, exp_retry, exp_loss);
        end
    endtask

    task automatic test_loss_in_run();
        int n, w;
        bus_if.PLL_LOCKED = 1'b0;
        n = 0;
        do begin tick(); n++; end while (bus_if.RESET_OUT_N === 1'b1 && n < 50);
        total++;
        if (n != 3 || bus_if.READY !== 1'b0 || bus_if.PLL_ARESET !== 1'b1) begin
            bad++;
            $display("FAIL loss_fall_latency got=%0d ready=%b areset=%b want=3 ready=0 areset=1",
                     n, bus_if.READY, bus_if.PLL_ARESET);
        end
        exp_loss++;
        total++;
        if (bus_if.LOSS_CNT !== 8'(exp_loss)) begin
            bad++;
            $display("FAIL loss_count got=%0d want=%0d", bus_if.LOSS_CNT, exp_loss);
        end
        w = 0;
        while (bus_if.PLL_ARESET === 1'b1 && w < 100) begin w++; tick(); end
        total++;
        if (w != A) begin
            bad++;
            $display("FAIL loss_areset_width got=%0d want=%0d", w, A);
        end
    endtask

    task automatic test_sw_ignored_in_wait();
        int n;
        bit saw;
        repeat (2) tick();
        bus_if.SW_RESET_REQ = 1'b1;
        tick();
        bus_if.SW_RESET_REQ = 1'b0;
        saw = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus_if.PLL_ARESET === 1'b1 || bus_if.RESET_OUT_N === 1'b1) saw = 1;
            tick();
        end
        bus_if.PLL_LOCKED = 1'b1;
        wait_for_run(n, saw);
        total++;
        if (n != S + 3 || saw || bus_if.RETRY_CNT !== 8'(exp_retry)) begin
            bad++;
            $display("FAIL sw_in_wait got=lat%0d areset=%0b retry=%0d want=lat%0d areset=0 retry=%0d",
                     n, saw, bus_if.RETRY_CNT, S + 3, exp_retry);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        bit saw;
        bus_if.PLL_LOCKED = 1'b0;
        tick();
        tick();
        bus_if.SW_RESET_REQ = 1'b1;
        tick();
        bus_if.SW_RESET_REQ = 1'b0;
        exp_loss++;
        total++;
        if (bus_if.PLL_ARESET !== 1'b1 || bus_if.RESET_OUT_N !== 1'b0 || bus_if.LOSS_CNT !== 8'(exp_loss)) begin
            bad++;
            $display("FAIL simultaneous_loss_wins got=areset%b rstn%b loss%0d want=areset1 rstn0 loss%0d",
                     bus_if.PLL_ARESET, bus_if.RESET_OUT_N, bus_if.LOSS_CNT, exp_loss);
        end
        bus_if.PLL_LOCKED = 1'b1;
        wait_for_run(n, saw);
        total++;
        if (n >= 400) begin
            bad++;
            $display("FAIL simultaneous_recover got=timeout want=run");
        end
    endtask

    task automatic test_chatter();
        int n;
        bit saw, saw2;
        lose_lock_and_wait();
        bus_if.PLL_LOCKED = 1'b1;
        saw = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_if.PLL_ARESET === 1'b1 || bus_if.RESET_OUT_N === 1'b1) saw = 1;
        end
        bus_if.PLL_LOCKED = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus_if.PLL_ARESET === 1'b1 || bus_if.RESET_OUT_N === 1'b1) saw = 1;
        end
        bus_if.PLL_LOCKED = 1'b1;
        wait_for_run(n, saw2);
        total++;
        if (n != S + 3 || saw || saw2) begin
            bad++;
            $display("FAIL chatter_restart got=lat%0d early=%0b areset=%0b want=lat%0d early=0 areset=0",
                     n, saw, saw2, S + 3);
        end
    endtask

    task automatic test_reset_in_stable();
        bus_if.SW_RESET_REQ = 1'b1;
        tick();
        bus_if.SW_RESET_REQ = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus_if.PLL_ARESET, bus_if.RESET_OUT_N, bus_if.READY} !== 3'b100 ||
            bus_if.RETRY_CNT !== 8'd0 || bus_if.LOSS_CNT !== 8'd0) begin
            bad++;
            $display("FAIL reset_in_stable got=%b retry=%0d loss=%0d want=100 retry=0 loss=0",
                     {bus_if.PLL_ARESET, bus_if.RESET_OUT_N, bus_if.READY},
                     bus_if.RETRY_CNT, bus_if.LOSS_CNT);
        end
        exp_loss  = 0;
        exp_retry = 0;
    endtask

    task automatic test_random();
        int         run_left;
        bit         lk, sw;
        logic [18:0] got, want;
        int         nfail;
        bus_if.PLL_LOCKED = 1'b0;
        do_reset();
        model_reset();
        run_left = 0;
        lk = 0;
        nfail = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                lk = ($urandom_range(0, 3) != 0);
                run_left = lk ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 45));
            end
            run_left--;
            sw = ($urandom_range(0, 7) == 0);
            bus_if.PLL_LOCKED   = lk;
            bus_if.SW_RESET_REQ = sw;
            tick();
            model_step(lk, sw);
            got  = {bus_if.PLL_ARESET, bus_if.RESET_OUT_N, bus_if.READY, bus_if.RETRY_CNT, bus_if.LOSS_CNT};
            want = {m_phase == PH_ARST, m_phase == PH_RUN, m_phase == PH_RUN, 8'(m_retry), 8'(m_loss)};
            total++;
            if (got !== want) begin
                bad++;
                nfail++;
                if (nfail <= 10)
                    $display("FAIL random_cycle_%0d got=%h want=%h", c, got, want);
            end
            total++;
            if (bus_if.RESET_OUT_N === 1'b1 && bus_if.PLL_ARESET === 1'b1) begin
                bad++;
                $display("FAIL random_release_during_areset cycle=%0d got=both_high want=exclusive", c);
            end
        end
        bus_if.SW_RESET_REQ = 1'b0;
    endtask

    task automatic test_retry_saturation();
        int k, want;
        bus_if.PLL_LOCKED = 1'b0;
        do_reset();
        for (int t = 1; t <= 258 * P; t++) begin
            tick();
            k = t / P;
            if (t % P == 0 && (k <= 3 || k >= 254)) begin
                want = (k > 255) ? 255 : k;
                total++;
                if (bus_if.RETRY_CNT !== 8'(want) || bus_if.PLL_ARESET !== 1'b1) begin
                    bad++;
                    $display("FAIL retry_at_timeout_%0d got=%0d areset=%b want=%0d areset=1",
                             k, bus_if.RETRY_CNT, bus_if.PLL_ARESET, want);
                end
            end
            if (t % P == P - 1 && k < 3) begin
                total++;
                if (bus_if.RETRY_CNT !== 8'(k) || bus_if.PLL_ARESET !== 1'b0) begin
                    bad++;
                    $display("FAIL retry_before_timeout_%0d got=%0d areset=%b want=%0d areset=0",
                             k + 1, bus_if.RETRY_CNT, bus_if.PLL_ARESET, k);
                end
            end
            if (t % P == A && k >= 1 && k <= 3) begin
                total++;
                if (bus_if.PLL_ARESET !== 1'b0) begin
                    bad++;
                    $display("FAIL retry_pulse_width_%0d got=areset%b want=areset0", k, bus_if.PLL_ARESET);
                end
            end
        end
    endtask

    initial begin
        bus_if.PLL_LOCKED   = 1'b0;
        bus_if.SW_RESET_REQ = 1'b0;
        test_reset();
        test_bringup();
        test_sw_reset();
        test_loss_in_run();
        test_sw_ignored_in_wait();
        test_simultaneous();
        test_chatter();
        test_reset_in_stable();
        test_random();
        test_retry_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_crg_reset_sequencer
`default_nettype wire
